// File: rtl/fifo_arb_pkg.sv
// Shared types and sizing helpers for the FIFO write-port arbiter.
//   arb_state_t : arbiter FSM state (IDLE = free to pick, OWN = burst owner held)
//   idw()       : width of a producer index for n producers
//   cnt_w()     : width of a burst counter that must hold 0..max_burst
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_t;

  function automatic int idw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int max_burst);
    return (max_burst > 0) ? $clog2(max_burst + 1) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer handshake plus FIFO write-port bundle for fifo_wr_arbiter.
//   req_valid    : per-producer request, data on req_data valid
//   req_data     : packed producer data, slice i = [i*DWIDTH +: DWIDTH]
//   req_ready    : per-producer accept (transfer = valid & ready)
//   fifo_full    : from fifo.full
//   fifo_wr_en   : to fifo.wr_en
//   fifo_data_in : to fifo.data_in
//   grant_id     : index of the producer being written (0 when no write)
//   busy         : arbiter is holding a burst owner
// Modport slave is the arbiter side, master is the producers/FIFO side.
interface fifo_wr_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int DWIDTH = 5
);
  localparam int IDW = idw(NREQ);

  logic [NREQ-1:0]        req_valid;
  logic [NREQ*DWIDTH-1:0] req_data;
  logic [NREQ-1:0]        req_ready;
  logic                   fifo_full;
  logic                   fifo_wr_en;
  logic [DWIDTH-1:0]      fifo_data_in;
  logic [IDW-1:0]         grant_id;
  logic                   busy;

  modport slave (
    input  req_valid, req_data, fifo_full,
    output req_ready, fifo_wr_en, fifo_data_in, grant_id, busy
  );

  modport master (
    output req_valid, req_data, fifo_full,
    input  req_ready, fifo_wr_en, fifo_data_in, grant_id, busy
  );
endinterface

// File: rtl/rr_picker.sv
// Combinational rotating-priority scan.
//   valid     : request vector
//   base      : index with highest priority this cycle
//   sel       : first set bit scanning base, base+1, ... modulo NREQ (0 if none)
//   any_valid : at least one request present
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = idw(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IDW-1:0]  base,
  output logic [IDW-1:0]  sel,
  output logic            any_valid
);

  // Scan from the lowest priority upward so the last hit written is the
  // highest-priority one; avoids a break and keeps the loop static.
  always_comb begin
    int idx;
    idx       = 0;
    sel       = '0;
    any_valid = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(base) + k) % NREQ;
      if (valid[idx]) begin
        sel       = IDW'(idx);
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter in front of a single-write-port FIFO.
// A granted producer keeps the port for up to MAX_BURST consecutive writes;
// the write path is purely combinational (no added latency, never writes
// while fifo_full is high).
//   clk : system clock
//   rst : asynchronous active-low reset; all outputs forced low while 0
//   bus : fifo_wr_arbiter_if.slave (producer handshake + FIFO write port)
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int DWIDTH    = 5,
  parameter int MAX_BURST = 4
) (
  input logic            clk,
  input logic            rst,
  fifo_wr_arbiter_if.slave bus
);

  localparam int IDW  = idw(NREQ);
  localparam int CNTW = cnt_w(MAX_BURST);

  localparam logic [IDW-1:0]  LAST_ID   = IDW'(NREQ - 1);
  localparam logic [CNTW-1:0] LAST_BEAT = CNTW'(MAX_BURST - 1);

  arb_state_t      state_q, state_d;
  logic [IDW-1:0]  owner_q, owner_d;
  logic [IDW-1:0]  rr_q, rr_d;
  logic [CNTW-1:0] burst_q, burst_d;

  logic [IDW-1:0]  pick_sel, sel;
  logic            pick_any, sel_ok;
  logic [NREQ-1:0] ready_vec;
  logic            wr;

  // Modulo increment that works for non-power-of-two NREQ.
  function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] id);
    return (id == LAST_ID) ? '0 : id + IDW'(1);
  endfunction

  rr_picker #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .valid     (bus.req_valid),
    .base      (rr_q),
    .sel       (pick_sel),
    .any_valid (pick_any)
  );

  // Selection and output mux. Gating with rst makes every output drop
  // immediately on an asynchronous reset, not just at the next edge.
  always_comb begin
    sel       = (state_q == OWN) ? owner_q : pick_sel;
    sel_ok    = (state_q == OWN) ? bus.req_valid[owner_q] : pick_any;
    ready_vec = (rst && sel_ok && !bus.fifo_full) ? (NREQ'(1) << sel) : '0;
    wr        = |(bus.req_valid & ready_vec);

    bus.req_ready    = ready_vec;
    bus.fifo_wr_en   = wr;
    bus.fifo_data_in = wr ? bus.req_data[int'(sel)*DWIDTH +: DWIDTH] : '0;
    bus.grant_id     = wr ? sel : '0;
    bus.busy         = rst && (state_q == OWN);
  end

  // Next-state logic. IDLE never locks an owner while stalled, so a full
  // FIFO in IDLE leaves arbitration open to whoever is valid when space frees.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    burst_d = burst_q;
    unique case (state_q)
      IDLE: begin
        if (wr) begin
          if (MAX_BURST == 1) begin
            rr_d = next_id(sel);
          end else begin
            state_d = OWN;
            owner_d = sel;
            burst_d = CNTW'(1);
          end
        end
      end
      OWN: begin
        if (!bus.req_valid[owner_q]) begin
          // Owner withdrew: release without a transfer this cycle.
          state_d = IDLE;
          rr_d    = next_id(owner_q);
          burst_d = '0;
        end else if (wr) begin
          if (burst_q == LAST_BEAT) begin
            state_d = IDLE;
            rr_d    = next_id(owner_q);
            burst_d = '0;
          end else begin
            burst_d = burst_q + CNTW'(1);
          end
        end
        // Owner valid but FIFO full: hold everything, count frozen.
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      rr_q    <= '0;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      burst_q <= burst_d;
    end
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Shares the write port of the existing `fifo` (`wr_en`/`data_in`/`full`) among NREQ producers.
- Uses round-robin arbitration with bounded bursts: a granted producer keeps ownership for up to MAX_BURST consecutive writes.
- Pure control plus mux; the write path to the FIFO is combinational, so throughput is 1 write/cycle with zero added latency and no overflow window.
- Sits directly in front of `fifo`; the FIFO read side is untouched.

Parameters:
- NREQ, 4, number of producers (>=2).
- DWIDTH, 5, data width; must equal the `fifo` DWIDTH.
- MAX_BURST, 4, maximum consecutive writes granted to one owner (>=1).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- req_valid  in  NREQ  per-producer request; data on req_data is valid.
- req_data  in  NREQ*DWIDTH  packed producer data; slice i = bits [i*DWIDTH +: DWIDTH].
- req_ready  out  NREQ  per-producer accept; transfer i occurs when req_valid[i] && req_ready[i].
- fifo_full  in  1  from `fifo.full`.
- fifo_wr_en  out  1  to `fifo.wr_en`.
- fifo_data_in  out  DWIDTH  to `fifo.data_in`.
- grant_id  out  $clog2(NREQ)  index of the producer being written; meaningful only when fifo_wr_en=1, else 0.
- busy  out  1  1 while in OWN state.

Behaviour:
- State registers: state {IDLE, OWN}, owner, burst_cnt (0..MAX_BURST), rr_ptr.
- Reset (rst=0, async): state=IDLE, owner=0, burst_cnt=0, rr_ptr=0.
  - All outputs (req_ready, fifo_wr_en, fifo_data_in, grant_id, busy) are forced to 0 while rst=0.
  - Reset mid-burst abandons the burst; no write occurs in the reset cycle.
- Selection (combinational):
  - IDLE: sel = first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo NREQ.
  - OWN: sel = owner.
  - sel_ok = req_valid[sel].
- req_ready[i] = (i==sel) && sel_ok && !fifo_full. At most one bit is set.
- fifo_wr_en = |(req_valid & req_ready).
- fifo_data_in = req_data slice sel when fifo_wr_en=1, else 0.
- grant_id = sel when fifo_wr_en=1, else 0.
- Transitions from IDLE:
  - No valid, or fifo_full=1: stay IDLE; no register change. IDLE does not lock an owner while stalled.
  - Transfer with MAX_BURST=1: stay IDLE, rr_ptr=(sel+1)%NREQ.
  - Transfer with MAX_BURST>1: go to OWN, owner=sel, burst_cnt=1.
- Transitions from OWN:
  - req_valid[owner]=0: go to IDLE, rr_ptr=(owner+1)%NREQ, burst_cnt=0; no transfer this cycle.
  - fifo_full=1 with owner valid: hold; burst_cnt is not incremented.
  - Transfer with burst_cnt+1==MAX_BURST: go to IDLE, rr_ptr=(owner+1)%NREQ, burst_cnt=0.
  - Other transfer: burst_cnt++.
- Fairness:
  - After a burst ends, the next IDLE cycle picks from owner+1 onward.
  - A sole requester is re-granted in that same IDLE cycle, so no bubble between bursts.
- Producer rules:
  - req_valid, once asserted, stays high with stable data until the handshake.
  - Dropping valid in OWN ends the burst.
- Wrap-around: rr_ptr increments modulo NREQ; NREQ need not be a power of two.
- Simultaneous full deassert and new requests: arbitration uses current-cycle values only.
- No overflow: fifo_wr_en is never 1 while fifo_full=1.

Decomposition:
- Package fifo_arb_pkg:
  - state enum {IDLE, OWN};
  - IDW = $clog2(NREQ) helper;
  - burst counter width function $clog2(MAX_BURST+1).
- Sub-module rr_picker (combinational): inputs valid vector and base index; outputs sel index and any_valid. Rotating priority scan.
- fifo_wr_arbiter holds the FSM, counters and output mux.

Test Plan (NREQ=4, DWIDTH=5, MAX_BURST=4, driving `fifo` AWIDTH=8; deassert rst for 2 cycles first):
- Reset: rst=0 with all req_valid=1 -> req_ready=0000, fifo_wr_en=0, busy=0. After rst=1, first grant is to producer 0.
- Single producer: producer 2 valid continuously with data 5'h1F..5'h10 (16 words) -> 16 consecutive fifo_wr_en cycles, no bubble, grant_id=2 throughout, busy drops for 1 cycle every 4 writes.
- All four valid continuously -> grant_id sequence 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0... with one write per cycle.
- Full stall: fill FIFO to 255 entries, then producers 1 and 3 valid -> exactly one write (count 256). fifo_full=1 holds req_ready=0000 and burst_cnt frozen. After one FIFO read, the held owner resumes.
- Early release: producer 1 owns with burst_cnt=2, then drops valid; producer 3 valid -> next cycle IDLE grants 3 (rr_ptr=2 wraps past to 3). Wrap check: owner 3 ends -> rr_ptr=0.
- Async reset mid-burst: assert rst=0 between clock edges during producer 0's 3rd write -> outputs 0 immediately. After release, state=IDLE, rr_ptr=0, FIFO receives no partial writes.
